// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter with ownership lock for the shared I/O register port.
// Define IOARB_LOCK_TIMEOUT_EN to force-release a lock whose owner stops requesting.
module io_bus_arbiter #(
    parameter int LOCK_TIMEOUT = 16,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [1:0]        m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [15:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [15:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [1:0]        m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [15:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [15:0]       m1_rdata,
    output logic [ADDR_W-1:0] io_dread_addr,
    input  logic [15:0]       io_dread_data,
    output logic [ADDR_W-1:0] io_dwrite_addr,
    output logic [15:0]       io_dwrite_data,
    output logic [1:0]        io_dwrite_en,
    output logic [1:0]        owner,
    output logic              lock_abort
);

    localparam logic [1:0] UNLOCKED = 2'b00;
    localparam logic [1:0] OWN0     = 2'b01;
    localparam logic [1:0] OWN1     = 2'b10;

    if (LOCK_TIMEOUT < 1) begin : g_bad_cfg
        $error("io_bus_arbiter: LOCK_TIMEOUT must be at least 1");
    end

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;   // 1 = M1 was granted last, so M0 wins the next tie
    logic       rv0_q, rv1_q;
    logic       timeout;

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        case (state_q)
            OWN0:    m0_gnt = m0_req;
            OWN1:    m1_gnt = m1_req;
            default: begin
                if (m0_req && m1_req) begin
                    m0_gnt = last_q;
                    m1_gnt = !last_q;
                end else begin
                    m0_gnt = m0_req;
                    m1_gnt = m1_req;
                end
            end
        endcase
    end

    always_comb begin
        last_d  = last_q;
        state_d = state_q;
        if (m0_gnt)      last_d = 1'b0;
        else if (m1_gnt) last_d = 1'b1;
        case (state_q)
            UNLOCKED: begin
                if (m0_gnt && m0_lock)      state_d = OWN0;
                else if (m1_gnt && m1_lock) state_d = OWN1;
            end
            OWN0:    if (m0_gnt && !m0_lock) state_d = UNLOCKED;
            OWN1:    if (m1_gnt && !m1_lock) state_d = UNLOCKED;
            default: state_d = UNLOCKED;
        endcase
        if (timeout) state_d = UNLOCKED;
    end

    always_comb begin
        io_dread_addr  = '0;
        io_dwrite_data = '0;
        io_dwrite_en   = 2'b00;
        if (m0_gnt) begin
            io_dread_addr  = m0_addr;
            io_dwrite_data = m0_wdata;
            io_dwrite_en   = m0_we;
        end else if (m1_gnt) begin
            io_dread_addr  = m1_addr;
            io_dwrite_data = m1_wdata;
            io_dwrite_en   = m1_we;
        end
    end
    assign io_dwrite_addr = io_dread_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= UNLOCKED;
            last_q  <= 1'b1;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rv0_q   <= m0_gnt && (m0_we == 2'b00);
            rv1_q   <= m1_gnt && (m1_we == 2'b00);
        end
    end

    // Read data comes straight from the I/O system; the registered rvalid picks the target.
    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;
    assign m0_rdata  = io_dread_data;
    assign m1_rdata  = io_dread_data;
    assign owner     = state_q;

`ifdef IOARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q;
    logic             idle;

    assign idle    = (state_q == OWN0 && !m0_req) || (state_q == OWN1 && !m1_req);
    assign timeout = idle && (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
    // Clearing on timeout means the counter never wraps while a lock is still held.
    assign cnt_d   = (idle && !timeout) ? cnt_q + CNT_W'(1) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= timeout;
        end
    end
    assign lock_abort = abort_q;
`else
    assign timeout    = 1'b0;
    assign lock_abort = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: expected grants per step, read returns via a scoreboard queue.
module tb_io_bus_arbiter;

    logic        clk, reset;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [1:0]  m0_we, m1_we;
    logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic [15:0] io_dread_addr, io_dread_data, io_dwrite_addr, io_dwrite_data;
    logic [1:0]  io_dwrite_en, owner;
    logic        lock_abort;

    io_bus_arbiter #(.LOCK_TIMEOUT(4), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .io_dread_addr(io_dread_addr), .io_dread_data(io_dread_data),
        .io_dwrite_addr(io_dwrite_addr), .io_dwrite_data(io_dwrite_data),
        .io_dwrite_en(io_dwrite_en), .owner(owner), .lock_abort(lock_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic        m;
        logic [15:0] d;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] cnum = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    // One bus cycle: drive after the edge, check at the falling edge, queue any read return.
    task automatic cyc(input string tag,
                       input logic r0, input logic l0, input logic [1:0] we0,
                       input logic [15:0] a0, input logic [15:0] wd0,
                       input logic r1, input logic l1, input logic [1:0] we1,
                       input logic [15:0] a1, input logic [15:0] wd1,
                       input logic eg0, input logic eg1, input logic [1:0] eown, input logic eab);
        exp_t        e;
        logic [15:0] ea, ed;
        logic [1:0]  een;
        @(posedge clk);
        #1;
        m0_req = r0; m0_lock = l0; m0_we = we0; m0_addr = a0; m0_wdata = wd0;
        m1_req = r1; m1_lock = l1; m1_we = we1; m1_addr = a1; m1_wdata = wd1;
        cnum++;
        io_dread_data = 16'hA500 ^ cnum;
        @(negedge clk);
        if (q.size() == 0) begin
            e = '0;
            chk({tag, ".sb_empty"}, 32'(q.size()), 32'd1);
        end else begin
            e = q.pop_front();
        end
        chk({tag, ".rv0"}, 32'(m0_rvalid), 32'(e.vld && !e.m));
        chk({tag, ".rv1"}, 32'(m1_rvalid), 32'(e.vld && e.m));
        if (e.vld && !e.m) chk({tag, ".rdata0"}, 32'(m0_rdata), 32'(e.d));
        if (e.vld && e.m)  chk({tag, ".rdata1"}, 32'(m1_rdata), 32'(e.d));
        chk({tag, ".gnt0"}, 32'(m0_gnt), 32'(eg0));
        chk({tag, ".gnt1"}, 32'(m1_gnt), 32'(eg1));
        chk({tag, ".owner"}, 32'(owner), 32'(eown));
        chk({tag, ".abort"}, 32'(lock_abort), 32'(eab));
        ea = 16'h0; ed = 16'h0; een = 2'b00;
        if (eg0) begin ea = a0; ed = wd0; een = we0; end
        else if (eg1) begin ea = a1; ed = wd1; een = we1; end
        chk({tag, ".raddr"}, 32'(io_dread_addr), 32'(ea));
        chk({tag, ".waddr"}, 32'(io_dwrite_addr), 32'(ea));
        chk({tag, ".wdata"}, 32'(io_dwrite_data), 32'(ed));
        chk({tag, ".wen"}, 32'(io_dwrite_en), 32'(een));
        e.vld = (eg0 && we0 == 2'b00) || (eg1 && we1 == 2'b00);
        e.m   = eg1;
        e.d   = 16'hA500 ^ (cnum + 16'h1);
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b0;
        io_dread_data = 16'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.owner", 32'(owner), 32'd0);
        chk("rst.rv0", 32'(m0_rvalid), 32'd0);
        chk("rst.rv1", 32'(m1_rvalid), 32'd0);
        chk("rst.abort", 32'(lock_abort), 32'd0);
        chk("rst.gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        reset = 1'b1;
        q.push_back('0);

        // Single M0 read, then idle to collect its data
        cyc("t1_rd0", 1,0,2'b00,16'h0018,0, 0,0,0,0,0, 1,0,2'b00,0);
        cyc("t1_idle", 0,0,0,0,0, 0,0,0,0,0, 0,0,2'b00,0);

        // M1 alone, then both every cycle: round robin starting at M0
        cyc("t2_m1", 0,0,0,0,0, 1,0,2'b00,16'h0040,0, 0,1,2'b00,0);
        for (int i = 0; i < 6; i++)
            cyc("t2_rr", 1,0,2'b00,16'h0020 + 16'(i),0, 1,0,2'b00,16'h0050 + 16'(i),0,
                (i % 2) == 0, (i % 2) == 1, 2'b00, 0);
        cyc("t2_idle", 0,0,0,0,0, 0,0,0,0,0, 0,0,2'b00,0);

        // M1 locked write, M0 held off, M1 unlocking read, M0 granted next
        cyc("t3_lock", 0,0,0,0,0, 1,1,2'b11,16'h001A,16'h1234, 0,1,2'b00,0);
        cyc("t3_hold", 1,0,2'b00,16'h0030,0, 0,0,0,0,0, 0,0,2'b10,0);
        cyc("t3_hold", 1,0,2'b00,16'h0030,0, 0,0,0,0,0, 0,0,2'b10,0);
        cyc("t3_rel", 1,0,2'b00,16'h0030,0, 1,0,2'b00,16'h001C,0, 0,1,2'b10,0);
        cyc("t3_m0", 1,0,2'b00,16'h0030,0, 0,0,0,0,0, 1,0,2'b00,0);

        // Low-byte write, no rvalid, then idle bus
        cyc("t4_wr", 1,0,2'b01,16'h0028,16'hBEEF, 0,0,0,0,0, 1,0,2'b00,0);
        cyc("t4_idle", 0,0,0,0,0, 0,0,0,0,0, 0,0,2'b00,0);

        // Both lock at once: only the round-robin winner (M1) owns
        cyc("t5_both", 1,1,2'b00,16'h0060,0, 1,1,2'b00,16'h0062,0, 0,1,2'b00,0);
        cyc("t5_rel", 1,1,2'b00,16'h0060,0, 1,0,2'b00,16'h0062,0, 0,1,2'b10,0);
        cyc("t5_rr", 1,0,2'b00,16'h0060,0, 1,0,2'b00,16'h0062,0, 1,0,2'b00,0);
        cyc("t5_idle", 0,0,0,0,0, 0,0,0,0,0, 0,0,2'b00,0);

        // Reset while M0 owns the bus with a read in flight
        cyc("t6_lk", 1,1,2'b00,16'h0070,0, 0,0,0,0,0, 1,0,2'b00,0);
        cyc("t6_rd", 1,1,2'b00,16'h0072,0, 0,0,0,0,0, 1,0,2'b01,0);
        idle_inputs();
        reset = 1'b0;
        #1;
        chk("t6_rst.owner", 32'(owner), 32'd0);
        chk("t6_rst.rv0", 32'(m0_rvalid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst2.rv0", 32'(m0_rvalid), 32'd0);
        chk("t6_rst2.owner", 32'(owner), 32'd0);
        q.delete();
        q.push_back('0);
        reset = 1'b1;
        cyc("t6_tie", 1,0,2'b00,16'h0074,0, 1,0,2'b00,16'h0076,0, 1,0,2'b00,0);
        cyc("t6_idle", 0,0,0,0,0, 0,0,0,0,0, 0,0,2'b00,0);

        // Owner M0 goes quiet while M1 waits
        cyc("t7_lk", 1,1,2'b00,16'h0080,0, 0,0,0,0,0, 1,0,2'b00,0);
        for (int i = 0; i < 4; i++)
            cyc("t7_quiet", 0,0,0,0,0, 1,0,2'b00,16'h0082,0, 0,0,2'b01,0);
`ifdef IOARB_LOCK_TIMEOUT_EN
        cyc("t7_abort", 0,0,0,0,0, 1,0,2'b00,16'h0082,0, 0,1,2'b00,1);
        cyc("t7_after", 0,0,0,0,0, 0,0,0,0,0, 0,0,2'b00,0);
`else
        cyc("t7_quiet", 0,0,0,0,0, 1,0,2'b00,16'h0082,0, 0,0,2'b01,0);
        cyc("t7_rel", 1,0,2'b00,16'h0084,0, 1,0,2'b00,16'h0082,0, 1,0,2'b01,0);
        cyc("t7_m1", 0,0,0,0,0, 1,0,2'b00,16'h0082,0, 0,1,2'b00,0);
        cyc("t7_after", 0,0,0,0,0, 0,0,0,0,0, 0,0,2'b00,0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the I/O system's single peripheral register port (read address/data, write address/data/enables) between two masters.
- M0 is the CPU data port. M1 is a DMA/debug master.
- Round-robin arbitration, one access per cycle, plus a lock that keeps ownership for atomic multi-access sequences (e.g. a 16-bit timer counter read followed by a reload write).
- Sits between the masters and the I/O system. Read data returns with the I/O system's one-cycle registered latency.

Parameters:
- LOCK_TIMEOUT, 16, idle cycles a locked owner may go without requesting before the lock is forcibly released (used only with the optional feature).
- ADDR_W, 16, address width.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- mN_req  in  1  (N=0,1) master N requests an access this cycle.
- mN_lock  in  1  keep ownership after this access.
- mN_we  in  2  byte write enables: [0] low byte, [1] high byte. 2'b00 = read.
- mN_addr  in  ADDR_W  byte address.
- mN_wdata  in  16  write data.
- mN_gnt  out  1  access accepted this cycle (combinational).
- mN_rvalid  out  1  read data valid, one cycle after a granted read.
- mN_rdata  out  16  read data, meaningful only while mN_rvalid=1.
- io_dread_addr  out  ADDR_W  to the I/O system read address.
- io_dread_data  in  16  from the I/O system, registered, valid one cycle after the address.
- io_dwrite_addr  out  ADDR_W  to the I/O system write address.
- io_dwrite_data  out  16  to the I/O system write data.
- io_dwrite_en  out  2  to the I/O system write enables.
- owner  out  2  2'b00 unlocked, 2'b01 M0 owns, 2'b10 M1 owns.
- lock_abort  out  1  one-cycle pulse when a lock is force-released.

Behaviour:
- FSM states: UNLOCKED, OWN0, OWN1. A registered last_grant bit holds the round-robin pointer.
- Reset (reset=0, async):
  - state=UNLOCKED, last_grant=1 (M0 wins the first tie).
  - All registered outputs = 0: mN_rvalid=0, owner=0, lock_abort=0.
  - Timeout counter = 0.
- Grant rule in UNLOCKED:
  - One requester is granted.
  - Both requesting: grant the master other than last_grant.
  - No request: no grant.
- Grant rule in OWNx:
  - Only master x can be granted.
  - The other master's req is held off with gnt=0. It must keep req asserted; no request is dropped or queued.
- last_grant updates to the granted master on every grant, including grants made while locked.
- Downstream mux (combinational):
  - io_dread_addr and io_dwrite_addr = granted mN_addr.
  - io_dwrite_data = granted mN_wdata.
  - io_dwrite_en = granted mN_we.
  - No grant: io_dwrite_en=2'b00 and addresses/data = 0.
  - io_dwrite_en is never non-zero without a grant.
- Read return:
  - A granted access with mN_we=2'b00 sets mN_rvalid=1 on the next cycle only.
  - mN_rdata = io_dread_data, passed through.
  - Writes produce no rvalid.
  - Back-to-back reads give rvalid on consecutive cycles, in grant order.
  - The rvalid target is registered, so a grant switch never misroutes read data.
- Lock transitions:
  - Granted access with lock=1 from UNLOCKED goes to OWNx on the next cycle.
  - Granted access with lock=0 from OWNx goes to UNLOCKED on the next cycle. That access itself completes normally.
  - The other master can be granted on the first cycle in UNLOCKED. If it is waiting, it wins the tie because last_grant=x.
  - A lock=1 access in OWNx keeps the lock.
- owner mirrors the state register.
- Simultaneous events:
  - Both masters request with lock=1 in UNLOCKED: only the granted master takes ownership.
  - A read and a write to the same address are never issued by different masters in the same cycle (single grant).
- Reset mid-lock or mid-read: lock is dropped and a pending rvalid is cancelled (not asserted after reset release).

Optional Feature:
- Macro: IOARB_LOCK_TIMEOUT_EN.
- Defined:
  - A counter counts cycles in OWNx with mx_req=0, and clears on any owner request.
  - Reaching LOCK_TIMEOUT forces state to UNLOCKED next cycle and pulses lock_abort for one cycle.
  - Counter saturates/clears on release and never wraps to 0 while still locked.
- Not defined:
  - No counter. A lock lasts until the owner releases it or reset is asserted.
  - lock_abort is tied to 0.

Test Plan:
- Reset released, M0 reads addr 16'h0018 → m0_gnt=1 same cycle; io_dread_addr=16'h0018; next cycle m0_rvalid=1 with m0_rdata=io_dread_data (e.g. 16'h00A5); m1_rvalid stays 0.
- Both masters request reads every cycle for 6 cycles → grants alternate M0,M1,M0,M1,M0,M1; each rvalid lands on the matching master one cycle later.
- M1 writes 16'h1234, we=2'b11, addr 16'h001A, lock=1; M0 requesting throughout → owner=2'b10 from next cycle; m0_gnt=0 while locked; M1 read with lock=0 releases; M0 is granted the cycle after.
- M0 write with we=2'b01 to 16'h0028 while M1 is idle → io_dwrite_en=2'b01, io_dwrite_data=m0_wdata, no rvalid; idle cycle → io_dwrite_en=2'b00.
- Reset asserted the cycle after a granted M0 read and while owner=2'b01 → m0_rvalid never asserts; owner=0 immediately; first grant after release goes to M0 on a tie.
- With IOARB_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=4: M0 locks, then drops req → after 4 idle cycles lock_abort pulses 1 cycle, owner=0, and a waiting M1 is granted the next cycle.
